// File: rtl/rr_request_arbiter.sv
// rtl/rr_request_arbiter.sv - round-robin request arbiter, registered one-hot grant held until release
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module rr_request_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic [N-1:0]    grant_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            hold_expired;

  // Scan downward from ptr with wrap; the first set request wins.
  always_comb begin
    logic [31:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      pos = (32'(ptr) + 32'(N) - 32'(i)) % 32'(N);
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_idx   = pos[IDXW-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == HCW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? hold_cnt + HCW'(1) : '0;
      timeout  <= (state == GRANT) && req[grant_idx] && hold_expired;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt          = GRANT;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          idx_nxt            = win_idx;
          ptr_nxt            = (win_idx == '0) ? IDXW'(N - 1) : win_idx - IDXW'(1);
        end
      end
      GRANT: begin
        // Release (owner drop or hold limit) always passes through IDLE first.
        if (!req[grant_idx] || hold_expired) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= IDXW'(N - 1);
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

  assign grant_valid = |grant;

endmodule
